ex_mult_unit: RTL and testbench

//  EX-stage consumer of the RF_EX multiplier lane.

---
 rtl/ex_mult_unit_pkg.sv | 14 +
 rtl/mult_step.sv | 17 +
 rtl/ex_mult_unit.sv | 110 +++++++++++
 tb/tb_ex_mult_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mult_unit_pkg.sv
// rtl/ex_mult_unit_pkg.sv - shared state encoding and width defaults for the EX multiplier lane
package ex_mult_unit_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int BITS_PER_DEF = 2;
    localparam int IDX_W_DEF    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one shift-add step: acc + a * b_slice, modulo 2^DATA_W
module mult_step #(
    parameter int DATA_W   = 16,
    parameter int BITS_PER = 2
) (
    input  logic [DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]   a,
    input  logic [BITS_PER-1:0] b_slice,
    output logic [DATA_W-1:0]   sum
);

    logic [DATA_W-1:0] slice_ext;

    assign slice_ext = DATA_W'(b_slice);
    assign sum       = acc + a * slice_ext;

endmodule

// File: rtl/ex_mult_unit.sv
// rtl/ex_mult_unit.sv - iterative shift-add multiplier consuming the RF_EX mult lane
module ex_mult_unit
    import ex_mult_unit_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BITS_PER = BITS_PER_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mult_inst_vld,
    input  logic              mult_en,
    input  logic [DATA_W-1:0] mult_op1,
    input  logic [DATA_W-1:0] mult_op2,
    input  logic [DATA_W-1:0] mult_imm,
    input  logic              mult_imm_vld,
    input  logic              mult_invtRt,
    input  logic [IDX_W-1:0]  mult_done_idx,
    input  logic [IDX_W-1:0]  phy_addr_mult,
    input  logic              reg_wrt_mul,
    output logic              stall_mult,
    output logic              wb_vld,
    input  logic              wb_rdy,
    output logic [DATA_W-1:0] wb_result,
    output logic [IDX_W-1:0]  wb_done_idx,
    output logic [IDX_W-1:0]  wb_phy_addr,
    output logic              wb_reg_wrt
);

    localparam int N     = DATA_W / BITS_PER;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t            state, state_nxt;
    logic              accept;
    logic [DATA_W-1:0] a_q, b_q, acc_q, acc_step;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  done_idx_q, phy_addr_q;
    logic              reg_wrt_q;
    logic [DATA_W-1:0] b_sel;

    assign b_sel = (mult_imm_vld ? mult_imm : mult_op2) ^ {DATA_W{mult_invtRt}};

    mult_step #(
        .DATA_W   (DATA_W),
        .BITS_PER (BITS_PER)
    ) u_step (
        .acc     (acc_q),
        .a       (a_q),
        .b_slice (b_q[BITS_PER-1:0]),
        .sum     (acc_step)
    );

    // Flush overrides the handshake view so RF_EX and writeback see a clean abort cycle.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        stall_mult = 1'b0;
        wb_vld     = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            accept = ((state == IDLE) || ((state == DONE) && wb_rdy))
                     && mult_inst_vld && mult_en;
            stall_mult = (state == BUSY) || ((state == DONE) && !wb_rdy);
            wb_vld     = (state == DONE);
            case (state)
                IDLE:    if (accept) state_nxt = BUSY;
                BUSY:    if (cnt_q == '0) state_nxt = DONE;
                DONE:    if (wb_rdy) state_nxt = accept ? BUSY : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            done_idx_q <= '0;
            phy_addr_q <= '0;
            reg_wrt_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q        <= mult_op1;
                b_q        <= b_sel;
                acc_q      <= '0;
                cnt_q      <= CNT_W'(N - 1);
                done_idx_q <= mult_done_idx;
                phy_addr_q <= phy_addr_mult;
                reg_wrt_q  <= reg_wrt_mul;
            end else if (state == BUSY && !flush) begin
                acc_q <= acc_step;
                a_q   <= a_q << BITS_PER;
                b_q   <= b_q >> BITS_PER;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign wb_result   = acc_q;
    assign wb_done_idx = done_idx_q;
    assign wb_phy_addr = phy_addr_q;
    assign wb_reg_wrt  = reg_wrt_q;

endmodule

// File: tb/tb_ex_mult_unit.sv
// tb/tb_ex_mult_unit.sv - scoreboard bench for ex_mult_unit with a behavioural product model
module tb_ex_mult_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        mult_inst_vld = 1'b0;
    logic        mult_en = 1'b0;
    logic [15:0] mult_op1 = '0, mult_op2 = '0, mult_imm = '0;
    logic        mult_imm_vld = 1'b0, mult_invtRt = 1'b0;
    logic [5:0]  mult_done_idx = '0, phy_addr_mult = '0;
    logic        reg_wrt_mul = 1'b0;
    logic        stall_mult, wb_vld;
    logic        wb_rdy = 1'b1;
    logic [15:0] wb_result;
    logic [5:0]  wb_done_idx, wb_phy_addr;
    logic        wb_reg_wrt;

    ex_mult_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mult_inst_vld(mult_inst_vld), .mult_en(mult_en),
        .mult_op1(mult_op1), .mult_op2(mult_op2), .mult_imm(mult_imm),
        .mult_imm_vld(mult_imm_vld), .mult_invtRt(mult_invtRt),
        .mult_done_idx(mult_done_idx), .phy_addr_mult(phy_addr_mult),
        .reg_wrt_mul(reg_wrt_mul), .stall_mult(stall_mult), .wb_vld(wb_vld),
        .wb_rdy(wb_rdy), .wb_result(wb_result), .wb_done_idx(wb_done_idx),
        .wb_phy_addr(wb_phy_addr), .wb_reg_wrt(wb_reg_wrt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [5:0]  idx;
        logic [5:0]  phy;
        logic        wrt;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, acc_count = 0, done_count = 0, dropped = 0;
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] o1, o2, im, input logic iv, inv);
        int unsigned bv, p;
        bv = iv ? im : o2;
        if (inv) bv = ~bv & 32'hFFFF;
        p = o1 * bv;
        return p[15:0];
    endfunction

    // Monitor: samples on the falling edge, pops on handshake, pushes on every RF_EX advance.
    always @(negedge clk) begin
        if (!rst_n) begin
            dropped += q.size();
            q.delete();
            seen = 0;
        end else if (flush) begin
            chk(!stall_mult, "flush_stall", 32'(stall_mult), 0);
            chk(!wb_vld, "flush_wb_vld", 32'(wb_vld), 0);
            dropped += q.size();
            q.delete();
            seen = 0;
        end else begin
            if (q.size() == 0) begin
                chk(!wb_vld && !stall_mult, "idle_outputs", {30'b0, wb_vld, stall_mult}, 0);
            end else if (wb_vld) begin
                if (!seen) begin
                    chk(cyc - q[0].acc_cyc == 8, "latency", 32'(cyc - q[0].acc_cyc), 8);
                    seen = 1;
                end
                chk(wb_result == q[0].res, "wb_result", 32'(wb_result), 32'(q[0].res));
                chk(wb_done_idx == q[0].idx, "wb_done_idx", 32'(wb_done_idx), 32'(q[0].idx));
                chk(wb_phy_addr == q[0].phy, "wb_phy_addr", 32'(wb_phy_addr), 32'(q[0].phy));
                chk(wb_reg_wrt == q[0].wrt, "wb_reg_wrt", 32'(wb_reg_wrt), 32'(q[0].wrt));
                chk(stall_mult == !wb_rdy, "done_stall", 32'(stall_mult), 32'(!wb_rdy));
                if (wb_rdy) begin
                    void'(q.pop_front());
                    seen = 0;
                    done_count++;
                end
            end else begin
                chk(stall_mult, "busy_stall", 32'(stall_mult), 1);
                chk(cyc - q[0].acc_cyc < 8, "busy_overrun", 32'(cyc - q[0].acc_cyc), 7);
            end
            if (mult_inst_vld && mult_en && !stall_mult) begin
                exp_t e;
                e.res = model(mult_op1, mult_op2, mult_imm, mult_imm_vld, mult_invtRt);
                e.idx = mult_done_idx;
                e.phy = phy_addr_mult;
                e.wrt = reg_wrt_mul;
                e.acc_cyc = cyc + 1;
                q.push_back(e);
                acc_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] o1, o2, im, input logic iv, inv,
                           input logic [5:0] idx, phy, input logic wrt);
        mult_op1 = o1; mult_op2 = o2; mult_imm = im;
        mult_imm_vld = iv; mult_invtRt = inv;
        mult_done_idx = idx; phy_addr_mult = phy; reg_wrt_mul = wrt;
        mult_inst_vld = 1'b1; mult_en = 1'b1;
    endtask

    task automatic wait_accept(input int start, input bit rand_rdy);
        for (int i = 0; i < 200 && acc_count == start; i++) begin
            tick();
            if (rand_rdy) wb_rdy = 1'($urandom_range(0, 1));
        end
        chk(acc_count != start, "accept_timeout", 32'(acc_count), 32'(start + 1));
        mult_inst_vld = 1'b0;
    endtask

    task automatic issue(input logic [15:0] o1, o2, im, input logic iv, inv,
                         input logic [5:0] idx, phy, input logic wrt, input bit rand_rdy);
        int start;
        start = acc_count;
        present(o1, o2, im, iv, inv, idx, phy, wrt);
        wait_accept(start, rand_rdy);
    endtask

    task automatic drain();
        wb_rdy = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        chk(q.size() == 0, "drain", 32'(q.size()), 0);
    endtask

    task automatic check_zero(input string name);
        chk({stall_mult, wb_vld, wb_result, wb_done_idx, wb_phy_addr, wb_reg_wrt} == '0,
            name, 32'({stall_mult, wb_vld, wb_result, wb_done_idx, wb_phy_addr, wb_reg_wrt}), 0);
    endtask

    initial begin
        int d0, a0;
        #12;
        check_zero("reset_outputs");
        tick();
        rst_n = 1'b1;
        tick();

        issue(16'd3, 16'd5, 16'd0, 1'b0, 1'b0, 6'd1, 6'd10, 1'b1, 1'b0);
        drain();
        issue(16'h0007, 16'hFFFF, 16'h0009, 1'b1, 1'b0, 6'd2, 6'd11, 1'b1, 1'b0);
        drain();
        issue(16'h1234, 16'h0100, 16'h0000, 1'b0, 1'b0, 6'd3, 6'd12, 1'b0, 1'b0);
        drain();
        issue(16'h0002, 16'hFFFE, 16'h0000, 1'b0, 1'b1, 6'd4, 6'd13, 1'b1, 1'b0);
        drain();
        chk(model(16'h1234, 16'h0100, 0, 0, 0) == 16'h3400, "model_trunc",
            32'(model(16'h1234, 16'h0100, 0, 0, 0)), 32'h3400);

        // Back-to-back with writeback back-pressure
        d0 = done_count;
        wb_rdy = 1'b0;
        issue(16'h0011, 16'h0022, 16'h0000, 1'b0, 1'b0, 6'd5, 6'd20, 1'b1, 1'b0);
        a0 = acc_count;
        present(16'h0123, 16'h0045, 16'h0000, 1'b0, 1'b0, 6'd6, 6'd21, 1'b0);
        for (int i = 0; i < 20 && !wb_vld; i++) tick();
        chk(wb_vld, "a_done_timeout", 32'(wb_vld), 1);
        repeat (3) tick();
        wb_rdy = 1'b1;
        wait_accept(a0, 1'b0);
        drain();
        chk(done_count - d0 == 2, "b2b_once", 32'(done_count - d0), 2);

        // Flush during BUSY
        d0 = done_count;
        issue(16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0, 6'd7, 6'd22, 1'b1, 1'b0);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (12) tick();
        chk(done_count == d0, "flush_no_wb", 32'(done_count), 32'(d0));

        // Asynchronous reset during BUSY
        issue(16'h0F0F, 16'h0033, 16'h0000, 1'b0, 1'b0, 6'd8, 6'd23, 1'b1, 1'b0);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Disabled multiplier slot
        a0 = acc_count;
        present(16'h0005, 16'h0006, 16'h0000, 1'b0, 1'b0, 6'd9, 6'd24, 1'b1);
        mult_en = 1'b0;
        repeat (10) tick();
        mult_inst_vld = 1'b0;
        chk(acc_count == a0, "en_low_no_accept", 32'(acc_count), 32'(a0));

        // Randomized traffic with random writeback back-pressure
        for (int n = 0; n < 40; n++) begin
            issue(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  6'($urandom), 6'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        chk(acc_count == done_count + dropped, "accounting", 32'(acc_count), 32'(done_count + dropped));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
